// File: rtl/n_term_ram_io_pkg.sv
// Shared constants and types for the RAM_IO north-terminal loopback.
package n_term_ram_io_pkg;

  localparam int W1   = 4;
  localparam int W2   = 8;
  localparam int W4   = 16;
  localparam int WTOT = W1 + 2 * W2 + W4;

  // Bit offsets of each group inside the packed 36-bit wire vector.
  localparam int OFF_N2MID = W1;
  localparam int OFF_N2END = W1 + W2;
  localparam int OFF_N4    = W1 + 2 * W2;

  localparam int CFG_N1    = 0;
  localparam int CFG_N2MID = 1;
  localparam int CFG_N2END = 2;
  localparam int CFG_N4    = 3;

  localparam int CNT_W = $clog2(WTOT);

  typedef enum logic {RB_IDLE, RB_SHIFT} rb_state_t;

endpackage

// File: rtl/n_term_ram_io_readback.sv
// Readback engine: snapshots the raw incoming wires and shifts them out LSB first.
module n_term_ram_io_readback
  import n_term_ram_io_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rb_req,
  input  logic [WTOT-1:0] din,
  output logic            rb_busy,
  output logic            rb_valid,
  output logic            rb_dout
);

  rb_state_t        state;
  logic [WTOT-1:0]  shadow;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RB_IDLE;
      shadow <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        RB_IDLE: begin
          if (rb_req) begin
            shadow <= din;
            cnt    <= CNT_W'(WTOT - 1);
            state  <= RB_SHIFT;
          end
        end
        RB_SHIFT: begin
          // Zero fill leaves the shadow cleared once the last bit has gone out.
          shadow <= shadow >> 1;
          cnt    <= (cnt == '0) ? '0 : cnt - 1'b1;
          if (cnt == '0) state <= RB_IDLE;
        end
        default: state <= RB_IDLE;
      endcase
    end
  end

  assign rb_busy  = (state == RB_SHIFT);
  assign rb_valid = (state == RB_SHIFT);
  assign rb_dout  = shadow[0];

endmodule

// File: rtl/n_term_ram_io_loopback.sv
// North-terminal loopback for the RAM_IO column; readback engine built only with
// N_TERM_RAM_IO_READBACK_EN defined.
module n_term_ram_io_loopback
  import n_term_ram_io_pkg::*;
#(
  parameter logic [3:0] CFG_RESET = 4'b0000
) (
  input  logic          UserCLK,
  input  logic          rst,
  input  logic [W1-1:0] N1END,
  input  logic [W2-1:0] N2MID,
  input  logic [W2-1:0] N2END,
  input  logic [W4-1:0] N4END,
  output logic [W1-1:0] S1BEG,
  output logic [W2-1:0] S2BEG,
  output logic [W2-1:0] S2BEGb,
  output logic [W4-1:0] S4BEG,
  input  logic          cfg_en,
  input  logic          cfg_in,
  output logic          cfg_out,
  input  logic          rb_req,
  output logic          rb_busy,
  output logic          rb_valid,
  output logic          rb_dout
);

  logic [3:0]      cfg;
  logic [WTOT-1:0] live;
  logic [WTOT-1:0] pipe;
  logic [WTOT-1:0] sel;
  logic [WTOT-1:0] mixed;

  for (genvar i = 0; i < W1; i++) begin : g_s1
    assign live[i] = N1END[W1-1-i];
  end
  for (genvar i = 0; i < W2; i++) begin : g_s2
    assign live[OFF_N2MID+i] = N2MID[W2-1-i];
    assign live[OFF_N2END+i] = N2END[W2-1-i];
  end
  for (genvar i = 0; i < W4; i++) begin : g_s4
    assign live[OFF_N4+i] = N4END[W4-1-i];
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      cfg  <= CFG_RESET;
      pipe <= '0;
    end else begin
      pipe <= live;
      if (cfg_en) cfg <= {cfg[2:0], cfg_in};
    end
  end

  // Per-group mux select; the flop-driven select keeps mode switches on clock boundaries.
  assign sel = {{W4{cfg[CFG_N4]}}, {W2{cfg[CFG_N2END]}},
                {W2{cfg[CFG_N2MID]}}, {W1{cfg[CFG_N1]}}};
  assign mixed = (sel & pipe) | (~sel & live);

  assign S1BEG   = mixed[W1-1:0];
  assign S2BEG   = mixed[OFF_N2MID +: W2];
  assign S2BEGb  = mixed[OFF_N2END +: W2];
  assign S4BEG   = mixed[OFF_N4 +: W4];
  assign cfg_out = cfg[3];

`ifdef N_TERM_RAM_IO_READBACK_EN
  n_term_ram_io_readback u_readback (
    .clk      (UserCLK),
    .rst      (rst),
    .rb_req   (rb_req),
    .din      ({N4END, N2END, N2MID, N1END}),
    .rb_busy  (rb_busy),
    .rb_valid (rb_valid),
    .rb_dout  (rb_dout)
  );
`else
  logic unused_rb_req;
  assign unused_rb_req = rb_req;
  assign rb_busy  = 1'b0;
  assign rb_valid = 1'b0;
  assign rb_dout  = 1'b0;
`endif

endmodule

// File: tb/tb_n_term_ram_io_loopback.sv
// Bench for n_term_ram_io_loopback: directed loopback checks plus a readback scoreboard.
module tb_n_term_ram_io_loopback;

  logic        UserCLK = 1'b0;
  logic        rst;
  logic [3:0]  N1END;
  logic [7:0]  N2MID, N2END;
  logic [15:0] N4END;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG, S2BEGb;
  logic [15:0] S4BEG;
  logic        cfg_en, cfg_in, cfg_out;
  logic        rb_req, rb_busy, rb_valid, rb_dout;

  int checks = 0;
  int errors = 0;

  logic rb_q[$];
  int   runs[$];
  int   gaps[$];
  int   run_len = 0;
  int   gap_len = 0;
  bit   seen_run = 0;

  always #5 UserCLK = ~UserCLK;

  n_term_ram_io_loopback #(.CFG_RESET(4'b0000)) dut (
    .UserCLK (UserCLK), .rst (rst),
    .N1END (N1END), .N2MID (N2MID), .N2END (N2END), .N4END (N4END),
    .S1BEG (S1BEG), .S2BEG (S2BEG), .S2BEGb (S2BEGb), .S4BEG (S4BEG),
    .cfg_en (cfg_en), .cfg_in (cfg_in), .cfg_out (cfg_out),
    .rb_req (rb_req), .rb_busy (rb_busy), .rb_valid (rb_valid), .rb_dout (rb_dout)
  );

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic expect_transfer(input logic [35:0] snap);
`ifdef N_TERM_RAM_IO_READBACK_EN
    for (int i = 0; i < 36; i++) rb_q.push_back(snap[i]);
`else
    if (^snap === 1'bx) $display("note: snapshot has unknown bits");
`endif
  endtask

  task automatic wait_runs(input int n);
    for (int k = 0; k < 120 && runs.size() < n; k++) tick();
  endtask

  task automatic clear_tracking();
    runs.delete();
    gaps.delete();
    seen_run = 0;
  endtask

  // Monitor: every valid readback cycle pops one expected bit; run and gap lengths are recorded.
  always @(negedge UserCLK) begin
    if (rb_valid === 1'b1 || rb_busy === 1'b1) begin
      check("rb_valid_hi", {35'd0, rb_valid}, 36'd1);
      check("rb_busy_hi", {35'd0, rb_busy}, 36'd1);
      if (rb_q.size() == 0) begin
        check("rb_unexpected", 36'd1, 36'd0);
      end else begin
        check("rb_dout", {35'd0, rb_dout}, {35'd0, rb_q.pop_front()});
      end
      if (run_len == 0 && seen_run) gaps.push_back(gap_len);
      run_len++;
    end else begin
      if (run_len != 0) begin
        runs.push_back(run_len);
        seen_run = 1;
        gap_len  = 0;
      end
      run_len = 0;
      gap_len++;
    end
  end

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0; rb_req = 1'b0;
    N1END = 4'h0; N2MID = 8'h00; N2END = 8'h00; N4END = 16'h0001;
    tick(); tick();
    @(negedge UserCLK);
    check("rst_S4BEG", {20'd0, S4BEG}, {20'd0, 16'h8000});
    check("rst_rb", {33'd0, rb_valid, rb_busy, rb_dout}, 36'd0);
    check("rst_cfg_out", {35'd0, cfg_out}, 36'd0);
    tick();
    rst = 1'b0;

    // Combinational mapping on every group.
    N1END = 4'b0001; N2MID = 8'h01; N2END = 8'h03;
    #1;
    check("comb_S1BEG", {32'd0, S1BEG}, {32'd0, 4'b1000});
    check("comb_S2BEG", {28'd0, S2BEG}, {28'd0, 8'h80});
    check("comb_S2BEGb", {28'd0, S2BEGb}, {28'd0, 8'hC0});
    check("comb_S4BEG", {20'd0, S4BEG}, {20'd0, 16'h8000});

    // Shift 1,0,0,0 into cfg: S4 group becomes registered.
    cfg_en = 1'b1; cfg_in = 1'b1;
    tick();
    check("cfg_out_after1", {35'd0, cfg_out}, 36'd0);
    cfg_in = 1'b0;
    tick(); tick(); tick();
    cfg_en = 1'b0;
    check("cfg_out_after4", {35'd0, cfg_out}, 36'd1);
    N4END = 16'h00F0; N1END = 4'b0011; N2END = 8'h10;
    #1;
    check("reg_S4BEG_hold", {20'd0, S4BEG}, {20'd0, 16'h8000});
    check("live_S1BEG", {32'd0, S1BEG}, {32'd0, 4'b1100});
    check("live_S2BEGb", {28'd0, S2BEGb}, {28'd0, 8'h08});
    tick();
    check("reg_S4BEG_next", {20'd0, S4BEG}, {20'd0, 16'h0F00});

    // Single readback of N1END=A.
    N1END = 4'hA; N2MID = 8'h00; N2END = 8'h00; N4END = 16'h0000;
    clear_tracking();
    expect_transfer({16'h0000, 8'h00, 8'h00, 4'hA});
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    N1END = 4'h5;
    @(negedge UserCLK);
`ifdef N_TERM_RAM_IO_READBACK_EN
    check("rb_first_valid", {35'd0, rb_valid}, 36'd1);
`else
    check("rb_off_valid", {33'd0, rb_valid, rb_busy, rb_dout}, 36'd0);
`endif
    wait_runs(1);
`ifdef N_TERM_RAM_IO_READBACK_EN
    check("rb_single_runs", runs.size(), 36'd1);
    if (runs.size() >= 1) check("rb_single_len", runs[0], 36'd36);
`else
    check("rb_off_runs", runs.size(), 36'd0);
`endif

    // rb_req held high across two transfers.
    N1END = 4'h0; N2MID = 8'h81;
    clear_tracking();
    expect_transfer({16'h0000, 8'h00, 8'h81, 4'h0});
    expect_transfer({16'h0000, 8'h00, 8'h81, 4'h0});
    rb_req = 1'b1;
    repeat (51) tick();
    rb_req = 1'b0;
    wait_runs(2);
`ifdef N_TERM_RAM_IO_READBACK_EN
    check("rb_b2b_runs", runs.size(), 36'd2);
    if (runs.size() >= 2) begin
      check("rb_b2b_len0", runs[0], 36'd36);
      check("rb_b2b_len1", runs[1], 36'd36);
    end
    check("rb_b2b_gaps", gaps.size(), 36'd1);
    if (gaps.size() >= 1) check("rb_b2b_gap", gaps[0], 36'd1);
`else
    check("rb_off_b2b_runs", runs.size(), 36'd0);
`endif

    // Reset while bit 10 is on rb_dout.
    N2MID = 8'h00; N4END = 16'h8001;
    clear_tracking();
    expect_transfer({16'h8001, 8'h00, 8'h00, 4'h0});
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge UserCLK);
    check("rb_after_rst", {33'd0, rb_valid, rb_busy, rb_dout}, 36'd0);
    rb_q.delete();
    tick();
`ifdef N_TERM_RAM_IO_READBACK_EN
    check("rb_partial_runs", runs.size(), 36'd1);
    if (runs.size() >= 1) check("rb_partial_len", runs[0], 36'd11);
`else
    check("rb_off_partial_runs", runs.size(), 36'd0);
`endif
    N4END = 16'hC000; N1END = 4'h5;
    #1;
    check("rst_cfg_S4BEG", {20'd0, S4BEG}, {20'd0, 16'h0003});
    check("rst_cfg_out2", {35'd0, cfg_out}, 36'd0);

    clear_tracking();
    expect_transfer({16'hC000, 8'h00, 8'h00, 4'h5});
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    wait_runs(1);
`ifdef N_TERM_RAM_IO_READBACK_EN
    check("rb_fresh_runs", runs.size(), 36'd1);
    if (runs.size() >= 1) check("rb_fresh_len", runs[0], 36'd36);
`else
    check("rb_off_fresh_runs", runs.size(), 36'd0);
`endif
    check("rb_leftover", rb_q.size(), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
